// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - MIPS IF stage: PC register, imem req/ack fetch, IF/ID register.
// Optional IF_FLUSH_EN squashes the delay-slot instruction instead of executing it.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stallD,
  input  logic        redirect,
  input  logic [31:0] npc,
  output logic [31:0] InstrD,
  output logic [31:0] PC4D,
  output logic [31:0] PCD,
  output logic        validD
);

  typedef enum logic {S_REQ, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] pcd_q, pcd_d;
  logic        valid_q, valid_d;
  logic        redir_pend_q, redir_pend_d;
  logic [31:0] redir_tgt_q, redir_tgt_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_word_q, buf_word_d;

  logic        ack_ok;
  logic        redir_acc;
  logic        load;
  logic [31:0] load_word;
  logic [31:0] npc_aligned;
  logic [31:0] pc_plus4;
  logic [31:0] pc_target;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    pcd_d        = pcd_q;
    valid_d      = valid_q;
    redir_pend_d = redir_pend_q;
    redir_tgt_d  = redir_tgt_q;
    buf_valid_d  = buf_valid_q;
    buf_word_d   = buf_word_q;
    load         = 1'b0;
    load_word    = imem_rdata;

    ack_ok      = req_q & imem_ack;
    redir_acc   = redirect & ~stallD;
    npc_aligned = {npc[31:2], 2'b00};
    pc_plus4    = pc_q + 32'd4;
    pc_target   = redir_acc ? npc_aligned : (redir_pend_q ? redir_tgt_q : pc_plus4);

    case (state_q)
      S_REQ: begin
        if (ack_ok) begin
          if (!stallD) begin
            load = 1'b1;
          end else begin
            buf_word_d  = imem_rdata;
            buf_valid_d = 1'b1;
            state_d     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (buf_valid_q && !stallD) begin
          load        = 1'b1;
          load_word   = buf_word_q;
          buf_valid_d = 1'b0;
          state_d     = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // Request is a flop so it stays low through the reset cycle and drops at once on reset.
    req_d = (state_d == S_REQ);

    if (load) begin
      instr_d      = load_word;
      pcd_d        = pc_q;
      pc4_d        = pc_plus4;
      valid_d      = 1'b1;
      pc_d         = pc_target;
      redir_pend_d = 1'b0;
`ifdef IF_FLUSH_EN
      if (redir_acc || redir_pend_q) begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end
`endif
    end else if (redir_acc) begin
      redir_pend_d = 1'b1;
      redir_tgt_d  = npc_aligned;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      req_q        <= 1'b0;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_WORD;
      pc4_q        <= 32'd0;
      pcd_q        <= 32'd0;
      valid_q      <= 1'b0;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= 32'd0;
      buf_valid_q  <= 1'b0;
      buf_word_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      pcd_q        <= pcd_d;
      valid_q      <= valid_d;
      redir_pend_q <= redir_pend_d;
      redir_tgt_q  <= redir_tgt_d;
      buf_valid_q  <= buf_valid_d;
      buf_word_q   <= buf_word_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign InstrD    = instr_q;
  assign PC4D      = pc4_q;
  assign PCD       = pcd_q;
  assign validD    = valid_q;

endmodule
